// File: rtl/jump_target_unit_pkg.sv
// Shared definitions for the jump/branch target unit.
//   kind_e      : request kind encoding carried on in_kind
//   INSTR_BYTES : sequential PC increment / link offset
//   sext64      : sign-extends the low 'width' bits of raw to 64 bits
package jtu_pkg;

    typedef enum logic [1:0] {
        KIND_SEQ    = 2'd0,
        KIND_JAL    = 2'd1,
        KIND_JALR   = 2'd2,
        KIND_BRANCH = 2'd3
    } kind_e;

    localparam int unsigned INSTR_BYTES = 4;

    // Left-justify the field, then arithmetic-shift it back down so the
    // field's top bit fills the upper bits. Valid for 1 <= width <= 64.
    function automatic logic [63:0] sext64(input logic [63:0] raw, input int unsigned width);
        int unsigned sh;
        sh = 64 - width;
        return 64'($signed(raw << sh) >>> sh);
    endfunction

endpackage

// File: rtl/jump_target_unit_if.sv
// Request/result bundle between the decode/execute side and the jump target
// unit.
//   master : requester/consumer (drives request fields and out_ready)
//   slave  : jump_target_unit (drives in_ready, results and RAS prediction)
interface jump_target_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMM_W     = 21,
    parameter int unsigned RAS_DEPTH = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic [1:0]                     in_kind;
    logic                           br_taken;
    logic [XLEN-1:0]                pc;
    logic [XLEN-1:0]                rs1_val;
    logic [IMM_W-1:0]               imm;
    logic                           rd_is_link;
    logic                           rs1_is_link;
    logic                           out_valid;
    logic                           out_ready;
    logic [XLEN-1:0]                target;
    logic [XLEN-1:0]                link_addr;
    logic                           misaligned;
    logic [XLEN-1:0]                pred_target;
    logic                           pred_valid;
    logic [$clog2(RAS_DEPTH):0]     ras_count;

    modport master (
        output in_valid, in_kind, br_taken, pc, rs1_val, imm,
               rd_is_link, rs1_is_link, out_ready,
        input  in_ready, out_valid, target, link_addr, misaligned,
               pred_target, pred_valid, ras_count
    );

    modport slave (
        input  in_valid, in_kind, br_taken, pc, rs1_val, imm,
               rd_is_link, rs1_is_link, out_ready,
        output in_ready, out_valid, target, link_addr, misaligned,
               pred_target, pred_valid, ras_count
    );
endinterface

// File: rtl/jump_target_unit_ras_stack.sv
// Circular return-address stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : stack operations; both together replace the top entry
//   push_data  : value written on push
//   top        : top-of-stack value, 0 when empty
//   count      : entries held, saturating at RAS_DEPTH
//   empty      : count == 0
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              push_data,
    output logic [XLEN-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         empty
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;       // next free slot; top lives at ptr-1
    logic [PW-1:0]   top_idx;
    logic            replace;

    assign top_idx = ptr - PW'(1);
    assign empty   = (count == '0);
    assign top     = empty ? '0 : mem[top_idx];
    // pop+push on a non-empty stack rewrites the top in place
    assign replace = push && pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (replace) begin
            ptr   <= ptr;
        end else if (push) begin
            // when full, the write lands on the oldest entry
            ptr <= ptr + PW'(1);
            if (count != CW'(RAS_DEPTH))
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[replace ? top_idx : ptr] <= push_data;
    end

endmodule

// File: rtl/jump_target_unit.sv
// Jump/branch target unit: resolves next PC for SEQ/JAL/JALR/BRANCH,
// produces the link address and a misalignment flag, registered behind a
// valid/ready handshake. Optional return-address stack predicts JALR
// returns when JTU_RAS_EN is defined; otherwise the prediction outputs are 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : jump_target_unit_if slave (request, result, prediction)
module jump_target_unit
    import jtu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMM_W     = 21,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    jump_target_unit_if.slave   bus
);
    kind_e           kind;
    logic            accept;
    logic            out_valid_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] link_q;
    logic            mis_q;
    logic [XLEN-1:0] simm;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] nxt;

    assign kind         = kind_e'(bus.in_kind);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        simm        = XLEN'(sext64(64'(bus.imm), IMM_W));
        pc_plus4    = bus.pc + XLEN'(INSTR_BYTES);
        pc_plus_imm = bus.pc + simm;
        jalr_sum    = bus.rs1_val + simm;
        nxt         = pc_plus4;
        unique case (kind)
            KIND_SEQ:    nxt = pc_plus4;
            KIND_JAL:    nxt = pc_plus_imm;
            KIND_JALR:   nxt = jalr_sum & ~XLEN'(1);
            KIND_BRANCH: nxt = bus.br_taken ? pc_plus_imm : pc_plus4;
            default:     nxt = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            target_q    <= '0;
            link_q      <= '0;
            mis_q       <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            target_q    <= nxt;
            link_q      <= pc_plus4;
            mis_q       <= nxt[1];
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.target     = target_q;
    assign bus.link_addr  = link_q;
    assign bus.misaligned = mis_q;

`ifdef JTU_RAS_EN
    logic ras_push;
    logic ras_pop;
    logic ras_empty;

    // pop+push together (JALR x1/x5 -> x1/x5) replaces the top in ras_stack
    assign ras_push = accept && (kind == KIND_JAL || kind == KIND_JALR) && bus.rd_is_link;
    assign ras_pop  = accept && (kind == KIND_JALR) && bus.rs1_is_link;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (bus.pred_target),
        .count     (bus.ras_count),
        .empty     (ras_empty)
    );

    assign bus.pred_valid = !ras_empty;
`else
    logic unused_ras_links;

    assign unused_ras_links = ^{bus.rd_is_link, bus.rs1_is_link};
    assign bus.pred_target  = '0;
    assign bus.pred_valid   = 1'b0;
    assign bus.ras_count    = '0;
`endif

endmodule

// File: tb/tb_jump_target_unit.sv
module tb_jump_target_unit;
    import jtu_pkg::*;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned IMM_W     = 21;
    localparam int unsigned RAS_DEPTH = 8;
`ifdef JTU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jump_target_unit_if #(
        .XLEN      (XLEN),
        .IMM_W     (IMM_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) bus ();

    jump_target_unit #(
        .XLEN      (XLEN),
        .IMM_W     (IMM_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic bt,
                         input logic [31:0] p, input logic [31:0] r1, input logic [20:0] im,
                         input logic rdl, input logic r1l, input logic ordy);
        bus.in_valid    = v;
        bus.in_kind     = k;
        bus.br_taken    = bt;
        bus.pc          = p;
        bus.rs1_val     = r1;
        bus.imm         = im;
        bus.rd_is_link  = rdl;
        bus.rs1_is_link = r1l;
        bus.out_ready   = ordy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rc(input int unsigned n);
        return RAS_ON ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [31:0] rt(input logic [31:0] v);
        return RAS_ON ? v : 32'd0;
    endfunction

    initial begin
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 21'h0, 1'b0, 1'b0, 1'b1);
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_target", bus.target, 32'h0);
        check("rst_link", bus.link_addr, 32'h0);
        check("rst_mis", 32'(bus.misaligned), 32'd0);
        check("rst_ras_count", 32'(bus.ras_count), 32'd0);
        check("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
        check("rst_pred_target", bus.pred_target, 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #4 rst_n = 1'b1;
        tick;

        // JAL pc=0x100 imm=0x10, link push
        drive(1'b1, 2'd1, 1'b0, 32'h100, 32'h0, 21'h00010, 1'b1, 1'b0, 1'b1);
        tick;
        check("jal_out_valid", 32'(bus.out_valid), 32'd1);
        check("jal_target", bus.target, 32'h110);
        check("jal_link", bus.link_addr, 32'h104);
        check("jal_mis", 32'(bus.misaligned), 32'd0);
        check("jal_ras_count", 32'(bus.ras_count), rc(1));
        check("jal_pred_target", bus.pred_target, rt(32'h104));
        check("jal_pred_valid", 32'(bus.pred_valid), rc(1));

        // JALR return: rs1=0x2003 imm=-1 -> 0x2002, pops the RAS
        drive(1'b1, 2'd2, 1'b0, 32'h200, 32'h2003, 21'h1FFFFF, 1'b0, 1'b1, 1'b1);
        tick;
        check("jalr_target", bus.target, 32'h2002);
        check("jalr_mis", 32'(bus.misaligned), 32'd1);
        check("jalr_link", bus.link_addr, 32'h204);
        check("jalr_ras_count", 32'(bus.ras_count), 32'd0);
        check("jalr_pred_valid", 32'(bus.pred_valid), 32'd0);
        check("jalr_pred_target", bus.pred_target, 32'h0);

        // BRANCH pc=0x40 imm=-16
        drive(1'b1, 2'd3, 1'b1, 32'h40, 32'h0, 21'h1FFFF0, 1'b0, 1'b0, 1'b1);
        tick;
        check("br_taken_target", bus.target, 32'h30);
        check("br_taken_link", bus.link_addr, 32'h44);
        drive(1'b1, 2'd3, 1'b0, 32'h40, 32'h0, 21'h1FFFF0, 1'b0, 1'b0, 1'b1);
        tick;
        check("br_nt_target", bus.target, 32'h44);
        check("br_nt_mis", 32'(bus.misaligned), 32'd0);

        // SEQ with pc bit1 set -> misaligned target
        drive(1'b1, 2'd0, 1'b0, 32'h1002, 32'h0, 21'h0, 1'b1, 1'b0, 1'b1);
        tick;
        check("seq_target", bus.target, 32'h1006);
        check("seq_mis", 32'(bus.misaligned), 32'd1);
        check("seq_ras_count", 32'(bus.ras_count), 32'd0);

        // drain: out_ready with no accept clears out_valid
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 21'h0, 1'b0, 1'b0, 1'b1);
        tick;
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        check("drain_hold_target", bus.target, 32'h1006);

        // backpressure: A accepted, B stalls for 3 cycles
        drive(1'b1, 2'd1, 1'b0, 32'h300, 32'h0, 21'h00008, 1'b1, 1'b0, 1'b0);
        tick;
        check("stallA_target", bus.target, 32'h308);
        check("stallA_ras_count", 32'(bus.ras_count), rc(1));
        drive(1'b1, 2'd1, 1'b0, 32'h500, 32'h0, 21'h00020, 1'b1, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            tick;
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_hold_target", bus.target, 32'h308);
            check("stall_hold_link", bus.link_addr, 32'h304);
            check("stall_ras_count", 32'(bus.ras_count), rc(1));
        end
        bus.out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 32'(bus.in_ready), 32'd1);
        tick;
        check("stallB_target", bus.target, 32'h520);
        check("stallB_ras_count", 32'(bus.ras_count), rc(2));
        check("stallB_pred_target", bus.pred_target, rt(32'h504));

        // reset mid-stream with a pending result and 3 RAS entries
        drive(1'b1, 2'd1, 1'b0, 32'h600, 32'h0, 21'h00004, 1'b1, 1'b0, 1'b1);
        tick;
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_ras_count", 32'(bus.ras_count), rc(3));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 21'h0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ras_count", 32'(bus.ras_count), 32'd0);
        check("midrst_target", bus.target, 32'h0);
        check("midrst_pred_valid", 32'(bus.pred_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick;

        // 9 pushes, links 0x4..0x24: oldest overwritten, count saturates
        for (int unsigned i = 0; i < 9; i++) begin
            drive(1'b1, 2'd1, 1'b0, 32'(4 * i), 32'h0, 21'h0, 1'b1, 1'b0, 1'b1);
            tick;
            check("push_ras_count", 32'(bus.ras_count), rc((i + 1 > 8) ? 8 : i + 1));
        end
        check("full_pred_target", bus.pred_target, rt(32'h24));

        // 8 pops walk the top from 0x24 down to 0x8
        for (int unsigned k = 0; k < 8; k++) begin
            drive(1'b1, 2'd2, 1'b0, 32'h900, 32'h0, 21'h0, 1'b0, 1'b1, 1'b1);
            #1;
            check("pop_pred_target", bus.pred_target, rt(32'h24 - 32'(4 * k)));
            tick;
        end
        check("popped_ras_count", 32'(bus.ras_count), 32'd0);
        check("popped_pred_valid", 32'(bus.pred_valid), 32'd0);
        tick;
        check("pop_empty_ras_count", 32'(bus.ras_count), 32'd0);
        check("pop_empty_pred_valid", 32'(bus.pred_valid), 32'd0);
        check("pop_empty_pred_target", bus.pred_target, 32'h0);

        // JALR link->link: push on empty, replace top otherwise
        drive(1'b1, 2'd2, 1'b0, 32'h700, 32'h1000, 21'h0, 1'b1, 1'b1, 1'b1);
        tick;
        check("repl0_target", bus.target, 32'h1000);
        check("repl0_ras_count", 32'(bus.ras_count), rc(1));
        check("repl0_pred_target", bus.pred_target, rt(32'h704));
        drive(1'b1, 2'd2, 1'b0, 32'h800, 32'h1000, 21'h0, 1'b1, 1'b1, 1'b1);
        tick;
        check("repl1_ras_count", 32'(bus.ras_count), rc(1));
        check("repl1_pred_target", bus.pred_target, rt(32'h804));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
